// File: rtl/reg_bus_pkg.sv
// reg_bus_pkg: shared constants for the register-bus arbiter.
// Holds the FSM state encoding, requester port ids and the board channel
// number used by the optional write protection (BOARD_WRITE_PROTECT_EN).
package reg_bus_pkg;

    // FSM state encoding (kept as plain constants for legacy tools)
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    // Requester ids; also the bit index of each port in the request vector
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    // Upper address nibble of the board channel registers
    localparam logic [3:0] BOARD_CHAN = 4'd0;

    // True when an address nibble selects the board channel
    function automatic logic is_board_chan(input logic [3:0] addr_hi);
        return (addr_hi == BOARD_CHAN);
    endfunction

endpackage

// File: rtl/reg_bus_arbiter_if.sv
// reg_bus_arbiter_if: all bus signals around the register-bus arbiter.
// Bundles both requester ports (A = 1394 packet handler, B = local sequencer)
// and the shared register-file port. The slave modport is the arbiter's view;
// the master modport is the view of the surrounding requesters + register file.
//
// Handshake: a requester raises x_req with x_wr/x_addr/x_wdata valid and keeps
// all of them stable until it sees x_ack (a single-cycle pulse). x_rdata (and
// b_err for port B) are valid in the x_ack cycle; x_rdata then holds. Keeping
// x_req high in the cycle after x_ack requests a new transaction. Dropping
// x_req before x_ack does not cancel the transaction already accepted.
interface reg_bus_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    // requester A
    logic              a_req;
    logic              a_wr;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_ack;
    logic [DATA_W-1:0] a_rdata;

    // requester B
    logic              b_req;
    logic              b_wr;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_ack;
    logic [DATA_W-1:0] b_rdata;
    logic              b_err;

    // register-file port
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] reg_wdata;
    logic              wr_en;
    logic [DATA_W-1:0] reg_rdata;

    // status
    logic              busy;

    modport slave (
        input  a_req, a_wr, a_addr, a_wdata,
        output a_ack, a_rdata,
        input  b_req, b_wr, b_addr, b_wdata,
        output b_ack, b_rdata, b_err,
        output reg_addr, reg_wdata, wr_en,
        input  reg_rdata,
        output busy
    );

    modport master (
        output a_req, a_wr, a_addr, a_wdata,
        input  a_ack, a_rdata,
        output b_req, b_wr, b_addr, b_wdata,
        input  b_ack, b_rdata, b_err,
        input  reg_addr, reg_wdata, wr_en,
        output reg_rdata,
        input  busy
    );

endinterface

// File: rtl/arb_rr2.sv
// arb_rr2: combinational two-way round-robin picker.
// A lone request always wins; when both ports request, the port that was not
// granted last time wins, so neither requester can be starved.
module arb_rr2
    import reg_bus_pkg::*;
(
    input  logic [1:0] req,       // bit PORT_A = A request, bit PORT_B = B request
    input  logic       last_gnt,  // port id granted most recently
    output logic       gnt_valid, // at least one request present
    output logic       gnt_id     // winning port id (meaningful when gnt_valid)
);

    // Pick the winner: single requester wins outright, tie goes to the other port
    always_comb begin
        gnt_valid = |req;
        gnt_id    = PORT_A;
        case (req)
            2'b01:   gnt_id = PORT_A;
            2'b10:   gnt_id = PORT_B;
            2'b11:   gnt_id = ~last_gnt;
            default: gnt_id = PORT_A;
        endcase
    end

endmodule

// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: shares the single board register-file port between the
// 1394 packet handler (port A) and a local sequencer (port B) on sysclk.
// Transactions are serialised through IDLE -> ADDR -> [WAIT] -> DONE:
//   write: IDLE, ADDR (one-cycle wr_en pulse), DONE (ack)        = 3 cycles
//   read : IDLE, ADDR, WAIT x RD_LAT (capture reg_rdata), DONE   = 3 + RD_LAT
// Optional feature macro: BOARD_WRITE_PROTECT_EN. When defined, port B writes
// to the board channel (address bits [7:4] == 0) are dropped: no wr_en pulse,
// b_ack still pulses and b_err is raised with it. A traffic and B reads are
// never blocked. When undefined, b_err is constant 0.
// The board channel check uses address bits [7:4], so ADDR_W must be >= 8.
module reg_bus_arbiter
    import reg_bus_pkg::*;
#(
    parameter int ADDR_W = 8,  // register address width
    parameter int DATA_W = 32, // register data width
    parameter int RD_LAT = 1   // reg_addr valid to reg_rdata valid, 1..3 cycles
) (
    input  logic                sysclk,
    input  logic                reset,     // asynchronous, active low
    reg_bus_arbiter_if.slave    bus,
    output logic [1:0]          dbg_state  // current FSM state
);

    // Last WAIT cycle index; the 2-bit counter covers RD_LAT up to 4
    localparam logic [1:0] LAST_WAIT = 2'(RD_LAT - 1);

    logic [1:0]        state;
    logic              gnt;        // port owning the current transaction
    logic              last_gnt;   // port granted most recently
    logic              lat_wr;     // latched write/read flag
    logic [1:0]        wait_cnt;   // cycles spent in WAIT

    logic              gnt_valid;
    logic              gnt_id;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              blk_cand;   // winning request is a blocked board write

    arb_rr2 u_arb (
        .req       ({bus.b_req, bus.a_req}),
        .last_gnt  (last_gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // Route the arbitration winner's request fields toward the latches
    always_comb begin
        sel_wr    = bus.a_wr;
        sel_addr  = bus.a_addr;
        sel_wdata = bus.a_wdata;
        if (gnt_id == PORT_B) begin
            sel_wr    = bus.b_wr;
            sel_addr  = bus.b_addr;
            sel_wdata = bus.b_wdata;
        end
    end

`ifdef BOARD_WRITE_PROTECT_EN
    logic lat_blk; // current transaction is a rejected B board write

    assign blk_cand = (gnt_id == PORT_B) && bus.b_wr &&
                      is_board_chan(bus.b_addr[7:4]);

    // Remember whether the accepted transaction was rejected, for b_err
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            lat_blk <= 1'b0;
        end else if (state == IDLE && gnt_valid) begin
            lat_blk <= blk_cand;
        end
    end

    assign bus.b_err = (state == DONE) && (gnt == PORT_B) && lat_blk;
`else
    assign blk_cand  = 1'b0;
    assign bus.b_err = 1'b0;
`endif

    // Transaction FSM: grant, drive the register port, wait for read data
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            gnt       <= PORT_A;
            last_gnt  <= PORT_B;   // A wins the first tie
            lat_wr    <= 1'b0;
            wait_cnt  <= 2'd0;
            bus.reg_addr  <= '0;
            bus.reg_wdata <= '0;
            bus.wr_en     <= 1'b0;
        end else begin
            // wr_en is high only in the ADDR cycle following a grant
            bus.wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        gnt           <= gnt_id;
                        last_gnt      <= gnt_id;
                        lat_wr        <= sel_wr;
                        bus.reg_addr  <= sel_addr;
                        bus.reg_wdata <= sel_wdata;
                        bus.wr_en     <= sel_wr & ~blk_cand;
                        state         <= ADDR;
                    end
                end
                ADDR: begin
                    wait_cnt <= 2'd0;
                    state    <= lat_wr ? DONE : WAIT;
                end
                WAIT: begin
                    if (wait_cnt == LAST_WAIT) begin
                        state <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Capture read data for the owning port on the last WAIT cycle; hold otherwise
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            bus.a_rdata <= '0;
            bus.b_rdata <= '0;
        end else if (state == WAIT && wait_cnt == LAST_WAIT) begin
            if (gnt == PORT_A) begin
                bus.a_rdata <= bus.reg_rdata;
            end else begin
                bus.b_rdata <= bus.reg_rdata;
            end
        end
    end

    // Completion pulse and status decode straight from the state register
    assign bus.a_ack = (state == DONE) && (gnt == PORT_A);
    assign bus.b_ack = (state == DONE) && (gnt == PORT_B);
    assign bus.busy  = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb_reg_bus_arbiter: directed bench for reg_bus_arbiter with a register-file
// model of RD_LAT read latency. Single transactions come from a vector table;
// ties, back-to-back traffic and reset mid-read are hand-written sequences.
module tb_reg_bus_arbiter;
    import reg_bus_pkg::*;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 1;

    // ---------------- clock / reset ----------------
    logic       sysclk = 1'b0;
    logic       reset  = 1'b0;
    logic [1:0] dbg_state;

    always #5 sysclk = ~sysclk;

    reg_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    reg_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .sysclk    (sysclk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- register-file model ----------------
    logic [DATA_W-1:0] mem     [0:255];
    logic [DATA_W-1:0] rd_pipe [0:RD_LAT-1];

    always @(posedge sysclk) begin
        if (!reset) begin
            mem[8'h04] <= 32'h514C_4131;
        end else if (bus.wr_en) begin
            mem[bus.reg_addr] <= bus.reg_wdata;
        end
        rd_pipe[0] <= mem[bus.reg_addr];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.reg_rdata = rd_pipe[RD_LAT-1];

    // ---------------- monitor ----------------
    int          wr_cnt = 0;
    logic [7:0]  wr_addr_log = '0;
    logic [31:0] wr_data_log = '0;
    int          ack_a_cnt = 0;
    int          ack_b_cnt = 0;
    logic        log_en = 1'b0;
    logic [0:0]  ack_log[$];

    always @(negedge sysclk) begin
        if (bus.wr_en) begin
            wr_cnt++;
            wr_addr_log = bus.reg_addr;
            wr_data_log = bus.reg_wdata;
        end
        if (bus.a_ack) begin
            ack_a_cnt++;
            if (log_en) ack_log.push_back(PORT_A);
        end
        if (bus.b_ack) begin
            ack_b_cnt++;
            if (log_en) ack_log.push_back(PORT_B);
        end
    end

    // ---------------- scoreboard ----------------
    int         total = 0;
    int         bad   = 0;
    logic [0:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge sysclk);
        #1;
    endtask

    task automatic drive_port(input logic port, input logic req, input logic wr,
                              input logic [7:0] addr, input logic [31:0] wdata);
        if (port == PORT_A) begin
            bus.a_req = req; bus.a_wr = wr; bus.a_addr = addr; bus.a_wdata = wdata;
        end else begin
            bus.b_req = req; bus.b_wr = wr; bus.b_addr = addr; bus.b_wdata = wdata;
        end
    endtask

    // One transaction on one port; lat counts the IDLE cycle as cycle 1
    task automatic run_txn(input logic port, input logic wr, input logic [7:0] addr,
                           input logic [31:0] wdata, output int lat,
                           output logic [31:0] rdata, output logic err,
                           output int other_acks);
        logic done;
        done = 1'b0; lat = 0; rdata = '0; err = 1'b0; other_acks = 0;
        drive_port(port, 1'b1, wr, addr, wdata);
        for (int c = 1; c <= 20 && !done; c++) begin
            tick();
            if ((port == PORT_A) ? bus.b_ack : bus.a_ack) other_acks++;
            if ((port == PORT_A) ? bus.a_ack : bus.b_ack) begin
                done  = 1'b1;
                lat   = c + 1;
                rdata = (port == PORT_A) ? bus.a_rdata : bus.b_rdata;
                err   = bus.b_err;
                drive_port(port, 1'b0, wr, addr, wdata);
            end
        end
        drive_port(port, 1'b0, wr, addr, wdata);
        tick();
    endtask

    // Hold a request for n transactions, starting after start_delay cycles
    task automatic port_proc(input logic port, input int n, input logic wr,
                             input logic [7:0] addr, input logic [31:0] wdata,
                             input int start_delay, output int acks);
        acks = 0;
        repeat (start_delay) tick();
        drive_port(port, 1'b1, wr, addr, wdata);
        for (int c = 0; c < 200 && acks < n; c++) begin
            tick();
            if ((port == PORT_A) ? bus.a_ack : bus.b_ack) begin
                acks++;
                if (acks == n) drive_port(port, 1'b0, wr, addr, wdata);
            end
        end
        drive_port(port, 1'b0, wr, addr, wdata);
    endtask

    task automatic check_order(input string name);
        check({name, "_len"}, 32'(ack_log.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < ack_log.size(); i++) begin
            check($sformatf("%s_%0d", name, i), 32'(ack_log[i]), 32'(exp_q[i]));
        end
        ack_log.delete();
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a_ack"},    32'(bus.a_ack),   32'h0);
        check({tag, "_b_ack"},    32'(bus.b_ack),   32'h0);
        check({tag, "_b_err"},    32'(bus.b_err),   32'h0);
        check({tag, "_wr_en"},    32'(bus.wr_en),   32'h0);
        check({tag, "_busy"},     32'(bus.busy),    32'h0);
        check({tag, "_reg_addr"}, 32'(bus.reg_addr), 32'h0);
        check({tag, "_reg_wdata"}, bus.reg_wdata,   32'h0);
        check({tag, "_a_rdata"},  bus.a_rdata,      32'h0);
        check({tag, "_b_rdata"},  bus.b_rdata,      32'h0);
        check({tag, "_state"},    32'(dbg_state),   32'(IDLE));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        port;
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;   // read data (reads only)
        logic        exp_err;
        int          exp_wr;   // wr_en pulses expected
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    initial begin
        int          lat, other_acks, acks_a, acks_b, b_before;
        logic [31:0] rdata, a_model, b_model;
        logic        err;
        int          w0;

        drive_port(PORT_A, 1'b0, 1'b0, 8'h00, 32'h0);
        drive_port(PORT_B, 1'b0, 1'b0, 8'h00, 32'h0);

        vecs[0] = '{PORT_A, 1'b1, 8'h03, 32'h0000_0100, 32'h0,          1'b0, 1};
        vecs[1] = '{PORT_A, 1'b0, 8'h04, 32'h0,          32'h514C_4131, 1'b0, 0};
        vecs[2] = '{PORT_B, 1'b0, 8'h03, 32'h0,          32'h0000_0100, 1'b0, 0};
        vecs[3] = '{PORT_B, 1'b1, 8'h12, 32'hDEAD_BEEF, 32'h0,          1'b0, 1};
        vecs[4] = '{PORT_A, 1'b0, 8'h12, 32'h0,          32'hDEAD_BEEF, 1'b0, 0};
        vecs[5] = '{PORT_B, 1'b0, 8'h04, 32'h0,          32'h514C_4131, 1'b0, 0};
        vecs[6] = '{PORT_A, 1'b1, 8'h00, 32'h55AA_0001, 32'h0,          1'b0, 1};
`ifdef BOARD_WRITE_PROTECT_EN
        vecs[7] = '{PORT_B, 1'b1, 8'h00, 32'h0008_0800, 32'h0,          1'b1, 0};
        vecs[8] = '{PORT_A, 1'b0, 8'h00, 32'h0,          32'h55AA_0001, 1'b0, 0};
        vecs[9] = '{PORT_B, 1'b0, 8'h00, 32'h0,          32'h55AA_0001, 1'b0, 0};
`else
        vecs[7] = '{PORT_B, 1'b1, 8'h00, 32'h0008_0800, 32'h0,          1'b0, 1};
        vecs[8] = '{PORT_A, 1'b0, 8'h00, 32'h0,          32'h0008_0800, 1'b0, 0};
        vecs[9] = '{PORT_B, 1'b0, 8'h00, 32'h0,          32'h0008_0800, 1'b0, 0};
`endif

        // ---- reset state ----
        reset = 1'b0;
        repeat (3) tick();
        check_all_zero("rst");
        reset = 1'b1;
        tick();
        check("rst_rel_busy", 32'(bus.busy), 32'h0);

        // ---- tie after reset: A, then B (alternation), then A again ----
        log_en = 1'b1;
        fork
            port_proc(PORT_A, 2, 1'b1, 8'h20, 32'hA0A0_0001, 0, acks_a);
            port_proc(PORT_B, 1, 1'b1, 8'h21, 32'hB0B0_0002, 0, acks_b);
        join
        tick();
        log_en = 1'b0;
        check("tie_acks_a", 32'(acks_a), 32'd2);
        check("tie_acks_b", 32'(acks_b), 32'd1);
        exp_q.push_back(PORT_A); exp_q.push_back(PORT_B); exp_q.push_back(PORT_A);
        check_order("tie_order");
        check("tie_mem_b", mem[8'h21], 32'hB0B0_0002);

        // ---- table-driven single transactions ----
        a_model = bus.a_rdata;
        b_model = bus.b_rdata;
        for (int i = 0; i < NV; i++) begin
            w0 = wr_cnt;
            run_txn(vecs[i].port, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                    lat, rdata, err, other_acks);
            if (!vecs[i].wr) begin
                if (vecs[i].port == PORT_A) a_model = vecs[i].exp_rd;
                else                        b_model = vecs[i].exp_rd;
            end
            check($sformatf("v%0d_lat", i), 32'(lat), vecs[i].wr ? 32'd3 : 32'(3 + RD_LAT));
            check($sformatf("v%0d_rdata", i), rdata,
                  (vecs[i].port == PORT_A) ? a_model : b_model);
            check($sformatf("v%0d_other_rdata", i),
                  (vecs[i].port == PORT_A) ? bus.b_rdata : bus.a_rdata,
                  (vecs[i].port == PORT_A) ? b_model : a_model);
            check($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_other_ack", i), 32'(other_acks), 32'd0);
            check($sformatf("v%0d_wr_pulses", i), 32'(wr_cnt - w0), 32'(vecs[i].exp_wr));
            if (vecs[i].exp_wr != 0) begin
                check($sformatf("v%0d_wr_addr", i), 32'(wr_addr_log), 32'(vecs[i].addr));
                check($sformatf("v%0d_wr_data", i), wr_data_log, vecs[i].wdata);
            end
        end

        // ---- B streams 4 reads, A asks once: A served after B's first ----
        log_en = 1'b1;
        fork
            port_proc(PORT_B, 4, 1'b0, 8'h04, 32'h0, 0, acks_b);
            port_proc(PORT_A, 1, 1'b0, 8'h03, 32'h0, 1, acks_a);
        join
        tick();
        log_en = 1'b0;
        check("b2b_acks_b", 32'(acks_b), 32'd4);
        check("b2b_acks_a", 32'(acks_a), 32'd1);
        exp_q.push_back(PORT_B); exp_q.push_back(PORT_A);
        exp_q.push_back(PORT_B); exp_q.push_back(PORT_B); exp_q.push_back(PORT_B);
        check_order("b2b_order");
        check("b2b_a_rdata", bus.a_rdata, 32'h0000_0100);
        check("b2b_b_rdata", bus.b_rdata, 32'h514C_4131);

        // ---- reset during WAIT of a B read ----
        drive_port(PORT_B, 1'b1, 1'b0, 8'h04, 32'h0);
        tick();
        check("midrst_state_addr", 32'(dbg_state), 32'(ADDR));
        tick();
        check("midrst_state_wait", 32'(dbg_state), 32'(WAIT));
        b_before = ack_b_cnt;
        reset = 1'b0;
        #1;
        check_all_zero("midrst");
        drive_port(PORT_B, 1'b0, 1'b0, 8'h04, 32'h0);
        repeat (3) tick();
        reset = 1'b1;
        repeat (3) tick();
        check("midrst_no_b_ack", 32'(ack_b_cnt - b_before), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'h0);
        run_txn(PORT_A, 1'b0, 8'h04, 32'h0, lat, rdata, err, other_acks);
        check("post_rst_lat", 32'(lat), 32'(3 + RD_LAT));
        check("post_rst_rdata", rdata, 32'h514C_4131);
        check("post_rst_b_rdata", bus.b_rdata, 32'h0);
        check("post_rst_other_ack", 32'(other_acks), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_bus_arbiter.md
Name: reg_bus_arbiter

Overview:
- Shares the single board register-file port (reg_addr / reg_wdata / wr_en / reg_rdata) between two requesters.
- Port A is the 1394 packet handler; port B is a local sequencer (PROM or status poller).
- Serialises transactions, drives wr_en as a one-cycle pulse and returns read data.
- Sits between the requesters and the register file on sysclk.

Parameters:
- ADDR_W, 8, register address width.
- DATA_W, 32, register data width.
- RD_LAT, 1, sysclk cycles from reg_addr valid to reg_rdata valid. Range 1-3.

Ports:
- sysclk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- a_req  in  1  A transaction request; held until a_ack.
- a_wr  in  1  A write (1) / read (0).
- a_addr  in  ADDR_W  A register address.
- a_wdata  in  DATA_W  A write data.
- a_ack  out  1  A completion pulse, one cycle.
- a_rdata  out  DATA_W  A read data; valid with a_ack, then held.
- b_req, b_wr, b_addr, b_wdata, b_ack, b_rdata: same as the A signals, for B.
- b_err  out  1  B write rejected; valid with b_ack.
- reg_addr  out  ADDR_W  register-file address.
- reg_wdata  out  DATA_W  register-file write data.
- wr_en  out  1  register-file write strobe.
- reg_rdata  in  DATA_W  register-file registered read data.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE; all outputs 0; last_gnt=B, so A wins the first tie.
- Reset mid-transaction: abort immediately; no ack issued; wr_en forced 0.
- FSM states: IDLE, ADDR, WAIT, DONE.
- IDLE:
  - If any req is high, choose a winner.
  - Tie: the port not equal to last_gnt wins (round-robin). Single request: that port wins.
  - Latch winner's wr/addr/wdata; set gnt, update last_gnt; next state ADDR.
  - No req: stay IDLE; reg_addr holds its last value; wr_en=0.
- ADDR (1 cycle):
  - reg_addr and reg_wdata driven from the latches.
  - wr_en = latched wr for exactly this cycle.
  - Next state: DONE if write; WAIT if read.
- WAIT:
  - Counter runs RD_LAT cycles with reg_addr held.
  - On the last cycle, capture reg_rdata into gnt port's x_rdata; next state DONE.
- DONE (1 cycle): pulse gnt port's x_ack; next state IDLE.
- Latency from req sampled in IDLE to ack:
  - Write: 3 cycles (IDLE, ADDR, DONE).
  - Read: 3 + RD_LAT cycles.
- Handshake:
  - Requester keeps inputs stable from req until ack.
  - req still high in the cycle after ack starts a new transaction.
  - req dropped mid-transaction: transaction still completes and ack still pulses.
- Non-granted x_rdata holds its previous value; the non-granted ack stays 0.
- A request arriving while busy waits; no request is ever lost.
- Exactly one wr_en pulse per write transaction. Write frequency therefore equals requester write frequency, so watchdog reset behaviour is unchanged.
- Back-to-back worst case: the waiting port is granted at the next IDLE, so it waits at most one transaction.

Optional Feature:
- Macro: BOARD_WRITE_PROTECT_EN.
- Defined:
  - A B write with b_addr[7:4]==0 (board channel) is blocked: ADDR keeps wr_en=0 and the FSM goes to DONE.
  - b_ack pulses with b_err=1.
  - B reads and all A traffic are unaffected.
- Undefined: b_err tied 0; all B writes pass.

Decomposition:
- Package reg_bus_pkg holds:
  - state encoding: IDLE=2'd0, ADDR=2'd1, WAIT=2'd2, DONE=2'd3;
  - port id constants: PORT_A=1'b0, PORT_B=1'b1;
  - BOARD_CHAN constant 4'd0.
- One sub-module, arb_rr2: combinational 2-way round-robin picker. Inputs: req[1:0], last_gnt. Outputs: gnt_valid, gnt_id.

Test Plan:
- A write 0x03 <= 0x0000_0100, B idle -> wr_en high exactly 1 cycle with reg_addr=0x03 and reg_wdata=0x100; a_ack 3 cycles after req.
- A read 0x04 with reg_rdata model returning 0x514C4131, RD_LAT=1 -> a_rdata=0x514C4131 with a_ack at cycle 4; b_ack stays 0.
- A and B request in the same cycle after reset -> A served first, then B. Repeat the tie -> B first (alternation).
- B holds req high for 4 back-to-back reads while A requests once -> A is granted right after the current B transaction.
- Reset asserted during WAIT of a B read -> no b_ack, all outputs 0, busy=0. After release, a new A request completes normally.
- BOARD_WRITE_PROTECT_EN defined, B write 0x00 <= 0x0008_0800 -> wr_en never asserted, b_ack with b_err=1. B write 0x12 -> wr_en pulse, b_err=0.
